// File: rtl/lsu_sq.sv
// Store queue: holds issued stores in program order until ROB commit, then drains them
// one at a time to LSU_EX, replaying the head store after D$ misses.
module lsu_sq #(
  parameter int SQ_DEPTH      = 8,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 6,
  parameter int MHQ_TAG_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     i_flush,
  output logic                     o_full,
  input  logic                     i_alloc_en,
  input  logic [TAG_WIDTH-1:0]     i_alloc_tag,
  input  logic [ADDR_WIDTH-1:0]    i_alloc_addr,
  input  logic [DATA_WIDTH-1:0]    i_alloc_data,
  input  logic [3:0]               i_alloc_lsu_func,
  input  logic                     i_rob_retire_en,
  input  logic [TAG_WIDTH-1:0]     i_rob_retire_tag,
  input  logic                     i_retire_stall,
  output logic                     o_retire_en,
  output logic [ADDR_WIDTH-1:0]    o_retire_addr,
  output logic [DATA_WIDTH-1:0]    o_retire_data,
  output logic [3:0]               o_retire_lsu_func,
  output logic [TAG_WIDTH-1:0]     o_retire_tag,
  input  logic                     i_update_sq_en,
  input  logic                     i_update_sq_replay,
  input  logic                     i_update_sq_retry,
  input  logic [MHQ_TAG_WIDTH-1:0] i_update_sq_mhq_tag,
  input  logic                     i_mhq_fill,
  input  logic [MHQ_TAG_WIDTH-1:0] i_mhq_fill_tag,
  output logic                     o_sq_retire_en,
  output logic [ADDR_WIDTH-1:0]    o_sq_retire_addr,
  output logic [3:0]               o_sq_retire_lsu_func
);
  // state     | meaning
  // S_IDLE    | head entry not yet known to be committed
  // S_READY   | head committed, launch when LSU_EX not stalled
  // S_LAUNCHED| head store in flight, waiting for LSU_EX result
  // S_WAIT_FILL| head missed, waiting for MHQ fill before replay
  localparam int SQ_TAG_WIDTH = $clog2(SQ_DEPTH);
  localparam int PTR_W        = SQ_TAG_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_READY, S_LAUNCHED, S_WAIT_FILL} state_t;

  state_t                     state, state_nxt;
  logic [PTR_W-1:0]           head, commit, tail, commit_nxt;
  logic [SQ_TAG_WIDTH-1:0]    head_idx, tail_idx, commit_idx;
  logic [ADDR_WIDTH-1:0]      addr_q [SQ_DEPTH];
  logic [DATA_WIDTH-1:0]      data_q [SQ_DEPTH];
  logic [3:0]                 func_q [SQ_DEPTH];
  logic [TAG_WIDTH-1:0]       tag_q  [SQ_DEPTH];
  logic                       wait_retry;
  logic [MHQ_TAG_WIDTH-1:0]   wait_tag;
  logic                       launch, done, alloc_ok, latch_wait;

  assign head_idx   = head[SQ_TAG_WIDTH-1:0];
  assign tail_idx   = tail[SQ_TAG_WIDTH-1:0];
  assign commit_idx = commit[SQ_TAG_WIDTH-1:0];
  assign o_full     = (tail - head) == PTR_W'(SQ_DEPTH);
  assign alloc_ok   = i_alloc_en && !o_full && !i_flush;
  assign commit_nxt = commit + PTR_W'(i_rob_retire_en);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head   <= '0;
      commit <= '0;
      tail   <= '0;
    end else begin
      commit <= commit_nxt;
      // flush keeps only the committed prefix, including a commit arriving this cycle
      if (i_flush)
        tail <= commit_nxt;
      else if (alloc_ok)
        tail <= tail + PTR_W'(1);
      if (done)
        head <= head + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      addr_q[tail_idx] <= i_alloc_addr;
      data_q[tail_idx] <= i_alloc_data;
      func_q[tail_idx] <= i_alloc_lsu_func;
      tag_q[tail_idx]  <= i_alloc_tag;
    end
  end

  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    done       = 1'b0;
    latch_wait = 1'b0;
    case (state)
      S_IDLE:
        if (head != commit)
          state_nxt = S_READY;
      S_READY:
        if (!i_retire_stall) begin
          launch    = 1'b1;
          state_nxt = S_LAUNCHED;
        end
      S_LAUNCHED:
        if (i_update_sq_en) begin
          if (!i_update_sq_replay) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end else if (i_mhq_fill &&
                       (i_update_sq_retry || i_mhq_fill_tag == i_update_sq_mhq_tag)) begin
            state_nxt = S_READY;
          end else begin
            latch_wait = 1'b1;
            state_nxt  = S_WAIT_FILL;
          end
        end
      S_WAIT_FILL:
        if (i_mhq_fill && (wait_retry || i_mhq_fill_tag == wait_tag))
          state_nxt = S_READY;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state                <= S_IDLE;
      wait_retry           <= 1'b0;
      wait_tag             <= '0;
      o_sq_retire_en       <= 1'b0;
      o_sq_retire_addr     <= '0;
      o_sq_retire_lsu_func <= '0;
    end else begin
      state <= state_nxt;
      if (latch_wait) begin
        wait_retry <= i_update_sq_retry;
        wait_tag   <= i_update_sq_mhq_tag;
      end
      o_sq_retire_en       <= done;
      o_sq_retire_addr     <= done ? addr_q[head_idx] : '0;
      o_sq_retire_lsu_func <= done ? func_q[head_idx] : '0;
    end
  end

  assign o_retire_en       = launch;
  assign o_retire_addr     = launch ? addr_q[head_idx] : '0;
  assign o_retire_data     = launch ? data_q[head_idx] : '0;
  assign o_retire_lsu_func = launch ? func_q[head_idx] : '0;
  assign o_retire_tag      = launch ? tag_q[head_idx]  : '0;

  // the ROB commits stores strictly in allocation order
  a_commit_order: assert property (@(posedge clk) disable iff (!n_rst)
    i_rob_retire_en |-> i_rob_retire_tag == tag_q[commit_idx]);

endmodule

// File: tb/tb_lsu_sq.sv
// Bench for lsu_sq: directed scenarios plus randomized traffic, checked against a
// queue-based model of program-order store commit and drain.
module tb_lsu_sq;
  localparam logic [3:0] F_SB = 4'd5, F_SH = 4'd6, F_SW = 4'd7;

  logic        clk = 1'b0, n_rst = 1'b0;
  logic        i_flush = 0, i_alloc_en = 0, i_rob_retire_en = 0, i_retire_stall = 0;
  logic [5:0]  i_alloc_tag = 0, i_rob_retire_tag = 0;
  logic [31:0] i_alloc_addr = 0, i_alloc_data = 0;
  logic [3:0]  i_alloc_lsu_func = 0;
  logic        i_update_sq_en = 0, i_update_sq_replay = 0, i_update_sq_retry = 0, i_mhq_fill = 0;
  logic [1:0]  i_update_sq_mhq_tag = 0, i_mhq_fill_tag = 0;
  logic        o_full, o_retire_en, o_sq_retire_en;
  logic [31:0] o_retire_addr, o_retire_data, o_sq_retire_addr;
  logic [3:0]  o_retire_lsu_func, o_sq_retire_lsu_func;
  logic [5:0]  o_retire_tag;

  lsu_sq dut (
    .clk(clk), .n_rst(n_rst), .i_flush(i_flush), .o_full(o_full),
    .i_alloc_en(i_alloc_en), .i_alloc_tag(i_alloc_tag), .i_alloc_addr(i_alloc_addr),
    .i_alloc_data(i_alloc_data), .i_alloc_lsu_func(i_alloc_lsu_func),
    .i_rob_retire_en(i_rob_retire_en), .i_rob_retire_tag(i_rob_retire_tag),
    .i_retire_stall(i_retire_stall), .o_retire_en(o_retire_en), .o_retire_addr(o_retire_addr),
    .o_retire_data(o_retire_data), .o_retire_lsu_func(o_retire_lsu_func),
    .o_retire_tag(o_retire_tag), .i_update_sq_en(i_update_sq_en),
    .i_update_sq_replay(i_update_sq_replay), .i_update_sq_retry(i_update_sq_retry),
    .i_update_sq_mhq_tag(i_update_sq_mhq_tag), .i_mhq_fill(i_mhq_fill),
    .i_mhq_fill_tag(i_mhq_fill_tag), .o_sq_retire_en(o_sq_retire_en),
    .o_sq_retire_addr(o_sq_retire_addr), .o_sq_retire_lsu_func(o_sq_retire_lsu_func)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  func;
  } st_t;

  st_t         q[$];          // allocated stores, oldest first; the first c are committed
  int          c = 0;
  int          busy = 0;      // 0 head not in flight, 1 in flight, 2 waiting for fill
  logic        w_retry = 0;
  logic [1:0]  w_tag = 0;
  logic        exp_sq = 0;
  logic [31:0] exp_sq_addr = 0;
  logic [3:0]  exp_sq_func = 0;
  int          live = 0;
  int          n_chk = 0, n_pass = 0;
  int          k_alloc, k_commit, k_flush, k_stall, k_upd, k_replay, k_fill;
  logic [3:0]  funcs [3];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic clear_pulses();
    i_alloc_en = 0; i_rob_retire_en = 0; i_flush = 0;
    i_update_sq_en = 0; i_update_sq_replay = 0; i_update_sq_retry = 0; i_mhq_fill = 0;
  endtask

  task automatic cycle();
    logic launched, full_pre;
    @(negedge clk);
    chk("full", o_full, q.size() == 8);
    chk("sq_ret_en", o_sq_retire_en, exp_sq);
    if (exp_sq) begin
      chk("sq_ret_addr", o_sq_retire_addr, exp_sq_addr);
      chk("sq_ret_func", o_sq_retire_lsu_func, exp_sq_func);
    end
    if (o_retire_en) begin
      chk("launch_ok", busy == 0 && c > 0 && !i_retire_stall, 1);
      if (q.size() > 0) begin
        chk("ret_addr", o_retire_addr, q[0].addr);
        chk("ret_data", o_retire_data, q[0].data);
        chk("ret_func", o_retire_lsu_func, q[0].func);
        chk("ret_tag", o_retire_tag, q[0].tag);
      end
    end
    if (busy == 0 && c > 0) begin
      if (o_retire_en) live = 0;
      else if (!i_retire_stall) live++;
      if (live > 4) begin
        chk("launch_live", o_retire_en, 1);
        live = 0;
      end
    end else live = 0;
    launched = o_retire_en;
    @(posedge clk);
    full_pre = (q.size() == 8);
    exp_sq = 0;
    if (busy == 1 && i_update_sq_en) begin
      if (!i_update_sq_replay) begin
        exp_sq = 1; exp_sq_addr = q[0].addr; exp_sq_func = q[0].func;
        void'(q.pop_front()); c--; busy = 0;
      end else if (i_mhq_fill && (i_update_sq_retry || i_mhq_fill_tag == i_update_sq_mhq_tag))
        busy = 0;
      else begin
        busy = 2; w_retry = i_update_sq_retry; w_tag = i_update_sq_mhq_tag;
      end
    end else if (busy == 2 && i_mhq_fill && (w_retry || i_mhq_fill_tag == w_tag))
      busy = 0;
    if (launched) busy = 1;
    if (i_rob_retire_en) c++;
    if (i_flush) begin
      while (q.size() > c) void'(q.pop_back());
    end else if (i_alloc_en && !full_pre)
      q.push_back('{i_alloc_tag, i_alloc_addr, i_alloc_data, i_alloc_lsu_func});
    #1;
    clear_pulses();
  endtask

  task automatic set_alloc(logic [5:0] tag, logic [31:0] addr, logic [3:0] func);
    i_alloc_en = 1; i_alloc_tag = tag; i_alloc_addr = addr;
    i_alloc_data = $urandom; i_alloc_lsu_func = func;
  endtask

  task automatic set_commit();
    if (c < q.size()) begin
      i_rob_retire_en = 1; i_rob_retire_tag = q[c].tag;
    end
  endtask

  task automatic drive_rand();
    if ($urandom_range(0, 99) < k_alloc)
      set_alloc(6'($urandom), $urandom, funcs[$urandom_range(0, 2)]);
    if ($urandom_range(0, 99) < k_commit) set_commit();
    i_flush        = $urandom_range(0, 99) < k_flush;
    i_retire_stall = $urandom_range(0, 99) < k_stall;
    if (busy == 1 && $urandom_range(0, 99) < k_upd) begin
      i_update_sq_en      = 1;
      i_update_sq_replay  = $urandom_range(0, 99) < k_replay;
      i_update_sq_retry   = $urandom_range(0, 99) < 30;
      i_update_sq_mhq_tag = 2'($urandom_range(0, 3));
    end
    i_mhq_fill     = $urandom_range(0, 99) < k_fill;
    i_mhq_fill_tag = 2'($urandom_range(0, 3));
  endtask

  task automatic knobs(int a, int cm, int f, int s, int u, int r, int fl);
    k_alloc = a; k_commit = cm; k_flush = f; k_stall = s; k_upd = u; k_replay = r; k_fill = fl;
  endtask

  task automatic drain(string tag);
    knobs(0, 100, 0, 10, 70, 20, 40);
    for (int i = 0; i < 300 && (q.size() > 0 || busy != 0); i++) begin
      drive_rand();
      cycle();
    end
    i_retire_stall = 0;
    chk(tag, q.size(), 0);
  endtask

  task automatic wait_launch(string tag);
    for (int i = 0; i < 8 && busy != 1; i++) cycle();
    chk(tag, busy, 1);
  endtask

  initial begin
    funcs[0] = F_SB; funcs[1] = F_SH; funcs[2] = F_SW;
    repeat (2) cycle();
    chk("rst_full", o_full, 0);
    chk("rst_ret_en", o_retire_en, 0);
    chk("rst_sq_en", o_sq_retire_en, 0);
    n_rst = 1;

    // fill to capacity, ninth alloc must be dropped
    for (int i = 0; i < 9; i++) begin
      set_alloc(6'(i), 32'h1000 + 32'(i * 4), F_SW);
      cycle();
    end
    chk("full8", o_full, 1);
    drain("drain_full");

    // single SB commit and completion
    set_alloc(6'd0, 32'h100, F_SB); cycle();
    set_commit(); cycle();
    wait_launch("sb_launch");
    i_update_sq_en = 1; cycle();
    cycle();

    // replay waiting on a specific MHQ tag
    set_alloc(6'd1, 32'h200, F_SW); cycle();
    set_commit(); cycle();
    wait_launch("rp_launch");
    i_update_sq_en = 1; i_update_sq_replay = 1; i_update_sq_mhq_tag = 2'd2; cycle();
    i_mhq_fill = 1; i_mhq_fill_tag = 2'd1; cycle();
    cycle(); cycle();
    chk("rp_no_relaunch", busy, 2);
    i_mhq_fill = 1; i_mhq_fill_tag = 2'd2; cycle();
    cycle();
    chk("rp_relaunch", busy, 1);
    // retry wakes on any fill; stall holds the launch
    i_update_sq_en = 1; i_update_sq_replay = 1; i_update_sq_retry = 1; cycle();
    i_retire_stall = 1;
    i_mhq_fill = 1; i_mhq_fill_tag = 2'd3; cycle();
    repeat (3) cycle();
    chk("stall_hold", busy, 0);
    i_retire_stall = 0; cycle();
    chk("retry_relaunch", busy, 1);
    i_update_sq_en = 1; cycle();
    cycle();

    // flush keeps the committed prefix; commit in the flush cycle counts
    i_retire_stall = 1;
    for (int i = 0; i < 4; i++) begin
      set_alloc(6'(10 + i), 32'h300 + 32'(i * 4), F_SH);
      cycle();
    end
    set_commit(); cycle();
    set_commit(); i_flush = 1; cycle();
    chk("flush_cnt", q.size(), 2);
    chk("flush_full", o_full, 0);
    set_alloc(6'd20, 32'h3f0, F_SB); cycle();
    drain("drain_flush");
    // flush with nothing committed empties the queue
    set_alloc(6'd21, 32'h400, F_SW); cycle();
    set_alloc(6'd22, 32'h404, F_SW); cycle();
    i_flush = 1; cycle();
    set_alloc(6'd23, 32'h408, F_SB); cycle();
    drain("drain_empty_flush");

    // random traffic across many wraps
    knobs(55, 45, 3, 25, 50, 30, 30);
    for (int i = 0; i < 400; i++) begin
      drive_rand();
      cycle();
    end
    drain("drain_rand");

    // reset while a store is in flight
    set_alloc(6'd30, 32'h500, F_SW); cycle();
    set_commit(); cycle();
    wait_launch("rst_launch");
    n_rst = 0;
    #1;
    chk("mid_rst_full", o_full, 0);
    chk("mid_rst_ret_en", o_retire_en, 0);
    chk("mid_rst_ret_addr", o_retire_addr, 0);
    chk("mid_rst_sq_en", o_sq_retire_en, 0);
    chk("mid_rst_sq_addr", o_sq_retire_addr, 0);
    q.delete(); c = 0; busy = 0; exp_sq = 0; live = 0;
    cycle();
    n_rst = 1;
    set_alloc(6'd31, 32'h600, F_SH); cycle();
    set_commit(); cycle();
    drain("drain_post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
